// File: rtl/temp_sensor_if_if.sv
// Data-memory write port of the temperature-sensor front end:
// a request/acknowledge handshake carrying one 32-bit word.
interface temp_sensor_if_if;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/temp_sensor_if.sv
// Periodic SPI-style temperature-sensor sampler that writes each frame into a
// fixed data-memory word, flags dropped sample ticks and counts completed writes.
module temp_sensor_if #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned DATA_BITS     = 16,
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter logic [31:0] TEMP_ADDR     = 32'd8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sdata,
  output logic             sclk,
  output logic             cs_n,
  output logic             overrun,
  output logic [7:0]       sample_count,
  temp_sensor_if_if.master mem
);
  localparam int unsigned PW = $clog2(SAMPLE_PERIOD);
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_WRITE   = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [PW-1:0]        period_r, period_s;
  logic [DW-1:0]        div_r, div_s;
  logic [BW-1:0]        bit_r, bit_s;
  logic [DATA_BITS-1:0] frame_r, frame_s, frame_shift_s;
  logic                 sclk_r, sclk_s;
  logic                 cs_n_r, cs_n_s;
  logic                 wr_req_r, wr_req_s;
  logic [31:0]          wr_data_r, wr_data_s;
  logic                 overrun_r, overrun_s;
  logic [7:0]           count_r, count_s;
  logic                 tick_s;

  assign tick_s        = enable && (period_r == PERIOD_LAST);
  assign frame_shift_s = (frame_r << 1) | DATA_BITS'(sdata);

  // Sample-period counter: runs only while enabled, wraps on the tick.
  always_comb begin
    period_s = period_r;
    if (!enable) begin
      period_s = {PW{1'b0}};
    end else if (period_r == PERIOD_LAST) begin
      period_s = {PW{1'b0}};
    end else begin
      period_s = period_r + PW'(1);
    end
  end

  // Sequencer next state and next values of every registered output.
  always_comb begin
    state_s   = state_r;
    div_s     = div_r;
    bit_s     = bit_r;
    frame_s   = frame_r;
    sclk_s    = sclk_r;
    cs_n_s    = cs_n_r;
    wr_req_s  = wr_req_r;
    wr_data_s = wr_data_r;
    overrun_s = overrun_r;
    count_s   = count_r;
    case (state_r)
      ST_IDLE: begin
        if (tick_s) begin
          state_s = ST_CONVERT;
          cs_n_s  = 1'b0;
          sclk_s  = 1'b0;
          div_s   = {DW{1'b0}};
          bit_s   = {BW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        // A tick while busy is dropped, never queued.
        if (tick_s) begin
          overrun_s = 1'b1;
        end else begin
          overrun_s = overrun_r;
        end
        if (div_r == DIV_LAST) begin
          div_s = {DW{1'b0}};
          if (sclk_r) begin
            frame_s = frame_shift_s;
            sclk_s  = 1'b0;
            if (bit_r == BIT_LAST) begin
              state_s   = ST_WRITE;
              cs_n_s    = 1'b1;
              wr_req_s  = 1'b1;
              wr_data_s = 32'(frame_shift_s);
              bit_s     = {BW{1'b0}};
            end else begin
              bit_s = bit_r + BW'(1);
            end
          end else begin
            sclk_s = 1'b1;
          end
        end else begin
          div_s = div_r + DW'(1);
        end
      end
      ST_WRITE: begin
        if (tick_s) begin
          overrun_s = 1'b1;
        end else begin
          overrun_s = overrun_r;
        end
        if (mem.wr_ack) begin
          wr_req_s = 1'b0;
          count_s  = count_r + 8'd1;
          state_s  = ST_IDLE;
        end else begin
          state_s = ST_WRITE;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        cs_n_s   = 1'b1;
        sclk_s   = 1'b0;
        wr_req_s = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      period_r  <= {PW{1'b0}};
      div_r     <= {DW{1'b0}};
      bit_r     <= {BW{1'b0}};
      frame_r   <= {DATA_BITS{1'b0}};
      sclk_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      wr_req_r  <= 1'b0;
      wr_data_r <= 32'd0;
      overrun_r <= 1'b0;
      count_r   <= 8'd0;
    end else begin
      state_r   <= state_s;
      period_r  <= period_s;
      div_r     <= div_s;
      bit_r     <= bit_s;
      frame_r   <= frame_s;
      sclk_r    <= sclk_s;
      cs_n_r    <= cs_n_s;
      wr_req_r  <= wr_req_s;
      wr_data_r <= wr_data_s;
      overrun_r <= overrun_s;
      count_r   <= count_s;
    end
  end

  assign sclk         = sclk_r;
  assign cs_n         = cs_n_r;
  assign overrun      = overrun_r;
  assign sample_count = count_r;
  assign mem.wr_req   = wr_req_r;
  assign mem.wr_data  = wr_data_r;
  assign mem.wr_addr  = TEMP_ADDR;
endmodule

// File: tb/tb_temp_sensor_if.sv
// Randomized self-checking bench for temp_sensor_if with a behavioural sensor
// and an expected-state model (write count, sticky overrun, fixed latencies).
module tb_temp_sensor_if;
  localparam int CLK_DIV   = 4;
  localparam int DATA_BITS = 16;
  localparam int PERIOD    = 300;
  localparam int CONV      = 2 * CLK_DIV * DATA_BITS;

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic       sdata  = 1'b0;
  logic       sclk, cs_n, overrun;
  logic [7:0] sample_count;

  temp_sensor_if_if mem_bus();

  temp_sensor_if #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .SAMPLE_PERIOD(PERIOD), .TEMP_ADDR(32'd8)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .sdata(sdata), .sclk(sclk),
    .cs_n(cs_n), .overrun(overrun), .sample_count(sample_count), .mem(mem_bus)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_count = 0;
  logic exp_overrun = 1'b0;
  logic [DATA_BITS-1:0] sensor_word = '0;

  // Sensor: bit k valid while sclk is high in the k-th high phase, junk while low.
  int   bit_idx = 0;
  logic prev_sclk = 1'b0;
  always @(negedge clock) begin
    if (cs_n) bit_idx = 0;
    else if (prev_sclk && !sclk) bit_idx = bit_idx + 1;
    prev_sclk = sclk;
    if (sclk && !cs_n && bit_idx < DATA_BITS) sdata = sensor_word[DATA_BITS-1-bit_idx];
    else sdata = 1'($urandom_range(0, 1));
  end

  task automatic wait_cs_low(input int bound, output int n);
    n = 0;
    while (cs_n !== 1'b0 && n <= bound) begin @(negedge clock); n++; end
    if (cs_n !== 1'b0) n = -1;
  endtask

  task automatic wait_wr_req(input int bound, output int n);
    n = 0;
    while (mem_bus.wr_req !== 1'b1 && n <= bound) begin @(negedge clock); n++; end
    if (mem_bus.wr_req !== 1'b1) n = -1;
  endtask

  task automatic ack_now();
    mem_bus.wr_ack = 1'b1;
    @(negedge clock);
    mem_bus.wr_ack = 1'b0;
    exp_count = (exp_count + 1) % 256;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; mem_bus.wr_ack = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++; if (cs_n !== 1'b1) begin tests_failed++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
    tests_run++; if (sclk !== 1'b0) begin tests_failed++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    tests_run++; if (mem_bus.wr_req !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_req: got %b want 0", mem_bus.wr_req); end
    tests_run++; if (mem_bus.wr_data !== 32'd0) begin tests_failed++; $display("FAIL reset_wr_data: got %h want 0", mem_bus.wr_data); end
    tests_run++; if (mem_bus.wr_addr !== 32'd8) begin tests_failed++; $display("FAIL reset_wr_addr: got %h want 8", mem_bus.wr_addr); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    tests_run++; if (sample_count !== 8'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", sample_count); end
    reset = 1'b0; exp_count = 0; exp_overrun = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    sensor_word = 16'h0026;
    enable = 1'b1;
    wait_cs_low(PERIOD + 5, n);
    tests_run++; if (n != PERIOD) begin tests_failed++; $display("FAIL basic_first_tick: got %0d cycles want %0d", n, PERIOD); end
    wait_wr_req(CONV + 5, n);
    tests_run++; if (n != CONV) begin tests_failed++; $display("FAIL basic_conv_latency: got %0d want %0d", n, CONV); end
    tests_run++; if (mem_bus.wr_data !== 32'h0000_0026) begin tests_failed++; $display("FAIL basic_data: got %h want 00000026", mem_bus.wr_data); end
    tests_run++; if (mem_bus.wr_addr !== 32'd8) begin tests_failed++; $display("FAIL basic_addr: got %h want 8", mem_bus.wr_addr); end
    ack_now();
    tests_run++; if (mem_bus.wr_req !== 1'b0) begin tests_failed++; $display("FAIL basic_req_drop: got %b want 0", mem_bus.wr_req); end
    tests_run++; if (sample_count !== 8'(exp_count)) begin tests_failed++; $display("FAIL basic_count: got %0d want %0d", sample_count, exp_count); end
    tests_run++; if (overrun !== exp_overrun) begin tests_failed++; $display("FAIL basic_overrun: got %b want %b", overrun, exp_overrun); end
  endtask

  task automatic test_random_frames();
    int n, d;
    logic bad;
    logic [DATA_BITS-1:0] w;
    for (int i = 0; i < 4; i++) begin
      w = DATA_BITS'($urandom); d = $urandom_range(0, 20); sensor_word = w; bad = 1'b0;
      wait_cs_low(PERIOD + 5, n);
      wait_wr_req(CONV + 5, n);
      tests_run++; if (n != CONV) begin tests_failed++; $display("FAIL rand_latency: got %0d want %0d", n, CONV); end
      tests_run++; if (mem_bus.wr_data !== 32'(w)) begin tests_failed++; $display("FAIL rand_data: got %h want %h", mem_bus.wr_data, 32'(w)); end
      for (int k = 0; k < d; k++) begin
        @(negedge clock);
        if (mem_bus.wr_req !== 1'b1 || mem_bus.wr_data !== 32'(w)) bad = 1'b1;
      end
      tests_run++; if (bad !== 1'b0) begin tests_failed++; $display("FAIL rand_hold: got unstable=%b want 0", bad); end
      ack_now();
      tests_run++; if (sample_count !== 8'(exp_count)) begin tests_failed++; $display("FAIL rand_count: got %0d want %0d", sample_count, exp_count); end
      tests_run++; if (overrun !== exp_overrun) begin tests_failed++; $display("FAIL rand_overrun: got %b want %b", overrun, exp_overrun); end
    end
  endtask

  task automatic test_stall();
    int n;
    logic bad = 1'b0;
    logic [DATA_BITS-1:0] w;
    w = DATA_BITS'($urandom); sensor_word = w;
    wait_cs_low(PERIOD + 5, n);
    wait_wr_req(CONV + 5, n);
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL stall_overrun_early: got %b want 0", overrun); end
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (mem_bus.wr_req !== 1'b1 || mem_bus.wr_data !== 32'(w)) bad = 1'b1;
    end
    exp_overrun = 1'b1;
    tests_run++; if (bad !== 1'b0) begin tests_failed++; $display("FAIL stall_hold: got unstable=%b want 0", bad); end
    tests_run++; if (overrun !== exp_overrun) begin tests_failed++; $display("FAIL stall_overrun: got %b want 1", overrun); end
    ack_now();
    tests_run++; if (sample_count !== 8'(exp_count)) begin tests_failed++; $display("FAIL stall_count: got %0d want %0d", sample_count, exp_count); end
    w = DATA_BITS'($urandom); sensor_word = w;
    wait_cs_low(PERIOD + 5, n);
    wait_wr_req(CONV + 5, n);
    tests_run++; if (mem_bus.wr_data !== 32'(w)) begin tests_failed++; $display("FAIL stall_next_data: got %h want %h", mem_bus.wr_data, 32'(w)); end
    ack_now();
  endtask

  task automatic test_reset_mid();
    int n;
    wait_cs_low(PERIOD + 5, n);
    repeat (50) @(negedge clock);
    reset = 1'b1;
    #1;
    tests_run++; if (cs_n !== 1'b1) begin tests_failed++; $display("FAIL rmid_cs_n: got %b want 1", cs_n); end
    tests_run++; if (sclk !== 1'b0) begin tests_failed++; $display("FAIL rmid_sclk: got %b want 0", sclk); end
    tests_run++; if (mem_bus.wr_req !== 1'b0) begin tests_failed++; $display("FAIL rmid_wr_req: got %b want 0", mem_bus.wr_req); end
    repeat (5) @(negedge clock);
    exp_count = 0; exp_overrun = 1'b0;
    tests_run++; if (overrun !== 1'b0 || sample_count !== 8'd0) begin tests_failed++; $display("FAIL rmid_state: got ovr=%b cnt=%0d want 0/0", overrun, sample_count); end
    reset = 1'b0;
    sensor_word = 16'hA5C3;
    wait_cs_low(PERIOD + 5, n);
    tests_run++; if (n != PERIOD) begin tests_failed++; $display("FAIL rmid_restart_tick: got %0d want %0d", n, PERIOD); end
    wait_wr_req(CONV + 5, n);
    tests_run++; if (mem_bus.wr_data !== 32'h0000_A5C3) begin tests_failed++; $display("FAIL rmid_data: got %h want 0000a5c3", mem_bus.wr_data); end
    ack_now();
    tests_run++; if (sample_count !== 8'(exp_count)) begin tests_failed++; $display("FAIL rmid_count: got %0d want %0d", sample_count, exp_count); end
  endtask

  task automatic test_tick_ack();
    int n;
    logic [DATA_BITS-1:0] w;
    wait_cs_low(PERIOD + 5, n);
    wait_wr_req(CONV + 5, n);
    repeat (PERIOD - CONV - 1) @(negedge clock);
    ack_now();
    exp_overrun = 1'b1;
    tests_run++; if (mem_bus.wr_req !== 1'b0) begin tests_failed++; $display("FAIL tack_req: got %b want 0", mem_bus.wr_req); end
    tests_run++; if (sample_count !== 8'(exp_count)) begin tests_failed++; $display("FAIL tack_count: got %0d want %0d", sample_count, exp_count); end
    tests_run++; if (overrun !== exp_overrun) begin tests_failed++; $display("FAIL tack_overrun: got %b want 1", overrun); end
    tests_run++; if (cs_n !== 1'b1) begin tests_failed++; $display("FAIL tack_discard: got cs_n=%b want 1", cs_n); end
    w = DATA_BITS'($urandom); sensor_word = w;
    wait_cs_low(PERIOD + 5, n);
    tests_run++; if (n != PERIOD) begin tests_failed++; $display("FAIL tack_next_tick: got %0d want %0d", n, PERIOD); end
    wait_wr_req(CONV + 5, n);
    tests_run++; if (mem_bus.wr_data !== 32'(w)) begin tests_failed++; $display("FAIL tack_next_data: got %h want %h", mem_bus.wr_data, 32'(w)); end
    ack_now();
  endtask

  task automatic test_wrap_and_disable();
    int n, total;
    logic bad = 1'b0;
    logic [DATA_BITS-1:0] w;
    total = 256 - exp_count;
    for (int i = 0; i < total; i++) begin
      w = DATA_BITS'($urandom); sensor_word = w;
      wait_cs_low(PERIOD + 5, n);
      wait_wr_req(CONV + 5, n);
      tests_run++; if (mem_bus.wr_data !== 32'(w)) begin tests_failed++; $display("FAIL wrap_data[%0d]: got %h want %h", i, mem_bus.wr_data, 32'(w)); end
      ack_now();
      tests_run++; if (sample_count !== 8'(exp_count)) begin tests_failed++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, sample_count, exp_count); end
    end
    tests_run++; if (sample_count !== 8'd0) begin tests_failed++; $display("FAIL wrap_zero: got %0d want 0", sample_count); end
    tests_run++; if (overrun !== exp_overrun) begin tests_failed++; $display("FAIL wrap_overrun: got %b want %b", overrun, exp_overrun); end
    w = DATA_BITS'($urandom); sensor_word = w;
    wait_cs_low(PERIOD + 5, n);
    repeat (20) @(negedge clock);
    enable = 1'b0;
    wait_wr_req(CONV + 5, n);
    tests_run++; if (n != CONV - 20) begin tests_failed++; $display("FAIL dis_latency: got %0d want %0d", n, CONV - 20); end
    tests_run++; if (mem_bus.wr_data !== 32'(w)) begin tests_failed++; $display("FAIL dis_data: got %h want %h", mem_bus.wr_data, 32'(w)); end
    ack_now();
    tests_run++; if (sample_count !== 8'(exp_count)) begin tests_failed++; $display("FAIL dis_count: got %0d want %0d", sample_count, exp_count); end
    for (int k = 0; k < 2 * PERIOD; k++) begin
      @(negedge clock);
      if (cs_n !== 1'b1 || mem_bus.wr_req !== 1'b0) bad = 1'b1;
    end
    tests_run++; if (bad !== 1'b0) begin tests_failed++; $display("FAIL dis_quiet: got activity=%b want 0", bad); end
  endtask

  initial begin
    mem_bus.wr_ack = 1'b0;
    test_reset();
    test_basic();
    test_random_frames();
    test_stall();
    test_reset_mid();
    test_tick_ack();
    test_wrap_and_disable();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/temp_sensor_if.md
# temp_sensor_if

Serial temperature-sensor front end that sits directly upstream of the `mips_cpu` data memory. It samples a 16-bit SPI-style sensor at a fixed period and deposits each frame into a fixed data-memory word through a request/acknowledge write port. The fever-check program then reads that word and decides "febre / sem febre". It also reports dropped samples and counts completed writes.

## Interface
- `CLK_DIV`, 4: `clock` cycles per `sclk` half-period; ≥1.
- `DATA_BITS`, 16: bits per sensor frame; 1..32.
- `SAMPLE_PERIOD`, 1000: `clock` cycles between sample ticks; must exceed 2·CLK_DIV·DATA_BITS+2.
- `TEMP_ADDR`, 32'd8: byte address of target data-memory word (word index 2).
- `clock` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `enable` input 1: sampling enable.
- `sdata` input 1: sensor serial data, MSB first.
- `sclk` output 1: sensor serial clock, idle low.
- `cs_n` output 1: sensor chip select, active low.
- `wr_req` output 1: data-memory write request.
- `wr_addr` output 32: constant `TEMP_ADDR`.
- `wr_data` output 32: zero-extended captured frame.
- `wr_ack` input 1: write accepted by memory-side arbiter.
- `overrun` output 1: sticky; a tick was dropped.
- `sample_count` output 8: completed writes, wraps 255→0.

## Operation
- Reset values (asserted asynchronously):
  - state IDLE; period counter 0; `cs_n`=1; `sclk`=0.
  - `wr_req`=0; `wr_data`=0; `overrun`=0; `sample_count`=0.
- Period counter:
  - Counts only while `enable`=1. At SAMPLE_PERIOD-1 it raises a one-cycle tick and wraps to 0.
  - `enable`=0 clears it to 0 immediately (next edge).
  - First tick falls on the SAMPLE_PERIOD-th enabled cycle.
- IDLE: a tick moves to CONVERT with `cs_n`←0, divider←0, bit counter←0.
- CONVERT:
  - `sclk` toggles every CLK_DIV cycles, starting low.
  - `sdata` is shifted into the frame register on the edge that drives `sclk` 1→0, i.e. at the end of each high phase. The sensor holds each bit stable while `sclk` is high.
  - After DATA_BITS high phases: `cs_n`←1, `sclk`←0, `wr_data`←{zeros, frame}, `wr_req`←1, go to WRITE.
- WRITE:
  - `wr_req` is held high and `wr_data` held stable until an edge with `wr_ack`=1.
  - On that edge: `wr_req`←0, `sample_count`+1 (mod 256), go to IDLE.
  - `wr_ack` while `wr_req`=0 is ignored.
- Overrun:
  - A tick arriving while in CONVERT or WRITE sets `overrun`=1 and is discarded; there is no queued sample.
  - `overrun` clears only on `reset`.
- Enable deassertion during CONVERT/WRITE: the transaction completes normally, then the block stays in IDLE.
- `wr_addr` is always `TEMP_ADDR`, including during reset.

## Timing
- Tick edge → `cs_n` low: 1 cycle.
- `cs_n` low → `wr_req` high: 2·CLK_DIV·DATA_BITS cycles (128 at defaults).
- `wr_req` high → low: 1 cycle after the first edge with `wr_ack`=1. A 0-wait ack gives a single-cycle `wr_req`.
- Simultaneous tick and `wr_ack` in WRITE: the write completes and the tick counts as overrun.
- Tick on the same edge the FSM returns to IDLE from WRITE: overrun, because the state is still WRITE on that edge.
- Reset mid-CONVERT or mid-WRITE:
  - Outputs return to reset values at once; `cs_n` rises and the frame is lost.
  - No write occurs.
- `sample_count` wrap: 255 plus one ack gives 0; no flag.

## Test plan
- Reset then `enable`=1, SAMPLE_PERIOD=300, sensor model returns 16'h0026 → `cs_n` falls 300 cycles after enable; `wr_req` rises 128 cycles later with `wr_data`=32'h00000026, `wr_addr`=8; ack next cycle → `sample_count`=1, `overrun`=0.
- Full system: sensor 16'h0026 (38 °C) through the CPU program → data_memory word 3 = 1. Sensor 16'h0024 (36 °C) → word 3 = 0.
- Hold `wr_ack`=0 for 400 cycles → `wr_req` stays high with stable data; tick during WRITE sets `overrun`=1. Ack → IDLE, and the next tick samples normally.
- Tick and `wr_ack` on the same edge → one write completes, `sample_count`+1, `overrun`=1.
- Assert `reset` 50 cycles into CONVERT → `cs_n`=1, `sclk`=0, `wr_req`=0 immediately; no write issued. Restart after reset yields a correct frame 16'hA5C3.
- Drive 256 samples with immediate ack → `sample_count` returns to 0; `enable`=0 mid-CONVERT completes that write, then no further `cs_n` activity.
